// File: rtl/calc_pkg.sv
// Shared types for the calculator control path; imported by calc_sequencer
// and operand_display_handler so both agree on the state and opcode encodings.
package calc_pkg;

  typedef enum logic [2:0] {
    S0_IDLE      = 3'b000,
    S1_OP1       = 3'b001,
    S2_OP1_WR    = 3'b010,
    S3_OP2       = 3'b011,
    S4_OP2_WR    = 3'b100,
    S5_CALCULATE = 3'b101
  } state_t;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_MUL = 2'b10,
    ALU_NEG = 2'b11
  } alu_op_t;

  // The operand entry states are the only non-idle states that wait on the user.
  function automatic logic is_busy_state(input state_t s);
    return !((s == S0_IDLE) || (s == S1_OP1) || (s == S3_OP2));
  endfunction

endpackage

// File: rtl/button_conditioner.sv
// Raw button to single-cycle accepted-edge pulse: 2-flop synchronizer,
// rising-edge detect, and a lockout window that swallows bounces and re-presses.
module button_conditioner #(
  parameter int LOCKOUT_CYCLES = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn_i,
  output logic pulse_o
);

  localparam int LW = $clog2(LOCKOUT_CYCLES + 1);
  localparam logic [LW-1:0] LOCK_LOAD = LW'(LOCKOUT_CYCLES);

  logic          sync1_q;
  logic          sync2_q;
  logic          prev_q;
  logic [LW-1:0] lock_q;
  logic [LW-1:0] lock_d;
  logic          accept_s;

  // Edge acceptance and lockout countdown.
  always_comb begin
    accept_s = sync2_q & ~prev_q & (lock_q == '0);
    lock_d   = lock_q;
    if (accept_s) begin
      lock_d = LOCK_LOAD;
    end else if (lock_q != '0) begin
      lock_d = lock_q - LW'(1);
    end else begin
      lock_d = lock_q;
    end
  end

  // Synchronizer, history flop and lockout counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      lock_q  <= '0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      lock_q  <= lock_d;
    end
  end

  assign pulse_o = accept_s;

endmodule

// File: rtl/calc_sequencer.sv
// Calculator control FSM: operand entry sequencing, write strobes, ALU start
// and done/timeout supervision, with registered status outputs.
module calc_sequencer
  import calc_pkg::*;
#(
  parameter int LOCKOUT_CYCLES = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       confirm,
  input  logic       cancel,
  input  logic [1:0] op_select,
  input  logic       alu_done,
  output logic [2:0] state,
  output logic       wr_strobe,
  output logic       alu_start,
  output logic [1:0] alu_op,
  output logic       result_valid,
  output logic       error,
  output logic       busy
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  state_t        state_q, state_d;
  logic [TW-1:0] tmo_q, tmo_d;
  alu_op_t       alu_op_q, alu_op_d;
  logic          wr_q, wr_d;
  logic          start_q, start_d;
  logic          rv_q, rv_d;
  logic          err_q, err_d;
  logic          busy_q, busy_d;
  logic          confirm_edge_s;
  logic          cancel_edge_s;

  button_conditioner #(.LOCKOUT_CYCLES(LOCKOUT_CYCLES)) u_confirm_cond (
    .clk     (clk),
    .reset_n (reset_n),
    .btn_i   (confirm),
    .pulse_o (confirm_edge_s)
  );

  button_conditioner #(.LOCKOUT_CYCLES(LOCKOUT_CYCLES)) u_cancel_cond (
    .clk     (clk),
    .reset_n (reset_n),
    .btn_i   (cancel),
    .pulse_o (cancel_edge_s)
  );

  // Next-state, timeout and status flag logic; cancel outranks every other event.
  always_comb begin
    state_d  = state_q;
    tmo_d    = '0;
    wr_d     = 1'b0;
    start_d  = 1'b0;
    rv_d     = rv_q;
    err_d    = err_q;
    alu_op_d = alu_op_q;

    if (state_q == S4_OP2_WR) begin
      alu_op_d = alu_op_t'(op_select);
    end else begin
      alu_op_d = alu_op_q;
    end

    if (cancel_edge_s) begin
      if (state_q != S0_IDLE) begin
        state_d = S0_IDLE;
        rv_d    = 1'b0;
        err_d   = 1'b0;
      end else begin
        state_d = S0_IDLE;
      end
    end else begin
      case (state_q)
        S0_IDLE: begin
          if (confirm_edge_s) begin
            state_d = S1_OP1;
            rv_d    = 1'b0;
            err_d   = 1'b0;
          end else begin
            state_d = S0_IDLE;
          end
        end
        S1_OP1: begin
          if (confirm_edge_s) begin
            state_d = S2_OP1_WR;
            wr_d    = 1'b1;
          end else begin
            state_d = S1_OP1;
          end
        end
        S2_OP1_WR: begin
          state_d = S3_OP2;
        end
        S3_OP2: begin
          if (confirm_edge_s) begin
            state_d = S4_OP2_WR;
            wr_d    = 1'b1;
          end else begin
            state_d = S3_OP2;
          end
        end
        S4_OP2_WR: begin
          state_d = S5_CALCULATE;
          start_d = 1'b1;
        end
        S5_CALCULATE: begin
          // A done pulse in the final timeout cycle still counts as success.
          if (alu_done) begin
            state_d = S0_IDLE;
            rv_d    = 1'b1;
          end else if (tmo_q == TMO_LAST) begin
            state_d = S0_IDLE;
            err_d   = 1'b1;
          end else begin
            state_d = S5_CALCULATE;
            tmo_d   = tmo_q + TW'(1);
          end
        end
        default: begin
          state_d = S0_IDLE;
        end
      endcase
    end

    busy_d = is_busy_state(state_d);
  end

  // State, counter and registered output flops.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S0_IDLE;
      tmo_q    <= '0;
      alu_op_q <= ALU_ADD;
      wr_q     <= 1'b0;
      start_q  <= 1'b0;
      rv_q     <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      tmo_q    <= tmo_d;
      alu_op_q <= alu_op_d;
      wr_q     <= wr_d;
      start_q  <= start_d;
      rv_q     <= rv_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
    end
  end

  assign state        = state_q;
  assign wr_strobe    = wr_q;
  assign alu_start    = start_q;
  assign alu_op       = alu_op_q;
  assign result_valid = rv_q;
  assign error        = err_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_calc_sequencer.sv
// Bench for calc_sequencer: directed scenarios plus random traffic, every
// output compared each cycle against an edge-indexed behavioural model.
module tb_calc_sequencer;

  localparam int L = 4;
  localparam int T = 16;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       confirm = 1'b0;
  logic       cancel = 1'b0;
  logic [1:0] op_select = 2'b00;
  logic       alu_done = 1'b0;
  logic [2:0] state;
  logic       wr_strobe, alu_start, result_valid, error, busy;
  logic [1:0] alu_op;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  // Model: button history indexed by edge number since reset release.
  bit   conf_h[$];
  bit   canc_h[$];
  int   n;
  int   last_conf, last_canc;
  int   m_state;
  int   s5_entry;
  bit   m_rv, m_err;
  logic [1:0] m_op;

  // Scenario observations.
  int   seq[$];
  int   wr_cnt, start_cnt, s5_cnt;

  always #5 clk = ~clk;

  calc_sequencer #(.LOCKOUT_CYCLES(L), .TIMEOUT_CYCLES(T)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .confirm      (confirm),
    .cancel       (cancel),
    .op_select    (op_select),
    .alu_done     (alu_done),
    .state        (state),
    .wr_strobe    (wr_strobe),
    .alu_start    (alu_start),
    .alu_op       (alu_op),
    .result_valid (result_valid),
    .error        (error),
    .busy         (busy)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h (edge %0d)", tag, obs, exp, n);
    end
  endtask

  task automatic model_reset();
    conf_h.delete();
    canc_h.delete();
    n = 0;
    last_conf = -1000;
    last_canc = -1000;
    m_state = 0;
    s5_entry = 0;
    m_rv = 1'b0;
    m_err = 1'b0;
    m_op = 2'b00;
  endtask

  // Apply the rules for the edge just taken, using the inputs sampled on it.
  task automatic model_step();
    bit c2, c3, k2, k3, co, ca;
    c2 = (n >= 2) ? conf_h[n-2] : 1'b0;
    c3 = (n >= 3) ? conf_h[n-3] : 1'b0;
    k2 = (n >= 2) ? canc_h[n-2] : 1'b0;
    k3 = (n >= 3) ? canc_h[n-3] : 1'b0;
    co = c2 && !c3 && (n - last_conf > L);
    ca = k2 && !k3 && (n - last_canc > L);
    if (co) last_conf = n;
    if (ca) last_canc = n;
    if (m_state == 4) m_op = op_select;
    if (ca) begin
      if (m_state != 0) begin
        m_state = 0;
        m_rv = 1'b0;
        m_err = 1'b0;
      end
    end else begin
      case (m_state)
        0: if (co) begin m_state = 1; m_rv = 1'b0; m_err = 1'b0; end
        1: if (co) m_state = 2;
        2: m_state = 3;
        3: if (co) m_state = 4;
        4: begin m_state = 5; s5_entry = n; end
        5: begin
          if (alu_done) begin
            m_state = 0;
            m_rv = 1'b1;
          end else if (n - s5_entry == T) begin
            m_state = 0;
            m_err = 1'b1;
          end
        end
        default: m_state = 0;
      endcase
    end
    conf_h.push_back(confirm);
    canc_h.push_back(cancel);
    n++;
  endtask

  task automatic check_all();
    chk("state", 8'(state), 8'(m_state));
    chk("wr_strobe", 8'(wr_strobe), 8'(m_state == 2 || m_state == 4));
    chk("alu_start", 8'(alu_start), 8'(m_state == 5 && s5_entry == n - 1));
    chk("alu_op", 8'(alu_op), 8'(m_op));
    chk("result_valid", 8'(result_valid), 8'(m_rv));
    chk("error", 8'(error), 8'(m_err));
    chk("busy", 8'(busy), 8'(m_state == 2 || m_state == 4 || m_state == 5));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_state"}, 8'(state), 8'd0);
    chk({tag, "_wr"}, 8'(wr_strobe), 8'd0);
    chk({tag, "_start"}, 8'(alu_start), 8'd0);
    chk({tag, "_op"}, 8'(alu_op), 8'd0);
    chk({tag, "_rv"}, 8'(result_valid), 8'd0);
    chk({tag, "_err"}, 8'(error), 8'd0);
    chk({tag, "_busy"}, 8'(busy), 8'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_all();
    if (seq.size() == 0 || seq[$] != int'(state)) seq.push_back(int'(state));
    wr_cnt    += int'(wr_strobe);
    start_cnt += int'(alu_start);
    s5_cnt    += int'(state == 3'd5);
  endtask

  // done_at: S5 cycle index (0-based) in which alu_done pulses, -1 for never.
  task automatic run(input int cycles, input int done_at);
    for (int i = 0; i < cycles; i++) begin
      alu_done = (done_at >= 0) && (m_state == 5) && (n == s5_entry + 1 + done_at);
      tick();
    end
    alu_done = 1'b0;
  endtask

  task automatic press(input bit c, input bit k, input int done_at);
    confirm = c;
    cancel  = k;
    run(1, done_at);
    confirm = 1'b0;
    cancel  = 1'b0;
  endtask

  task automatic clear_obs();
    seq.delete();
    seq.push_back(int'(state));
    wr_cnt = 0;
    start_cnt = 0;
    s5_cnt = 0;
  endtask

  initial begin
    int exp_seq[7];
    exp_seq = '{0, 1, 2, 3, 4, 5, 0};

    // Reset state.
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();

    // Full pass: sub, done in S5 cycle 3.
    op_select = 2'b01;
    clear_obs();
    for (int p = 0; p < 3; p++) begin
      press(1'b1, 1'b0, 3);
      run(9, 3);
    end
    chk("full_seq_len", 8'(seq.size()), 8'd7);
    for (int i = 0; i < 7 && i < seq.size(); i++) chk("full_seq", 8'(seq[i]), 8'(exp_seq[i]));
    chk("full_wr_cnt", 8'(wr_cnt), 8'd2);
    chk("full_start_cnt", 8'(start_cnt), 8'd1);
    chk("full_alu_op", 8'(alu_op), 8'd1);
    chk("full_rv", 8'(result_valid), 8'd1);
    chk("full_err", 8'(error), 8'd0);

    // Timeout: no done.
    op_select = 2'b11;
    clear_obs();
    for (int p = 0; p < 3; p++) begin
      press(1'b1, 1'b0, -1);
      run(9, -1);
    end
    run(15, -1);
    chk("tmo_s5_cycles", 8'(s5_cnt), 8'd16);
    chk("tmo_state", 8'(state), 8'd0);
    chk("tmo_err", 8'(error), 8'd1);
    chk("tmo_rv", 8'(result_valid), 8'd0);
    press(1'b1, 1'b0, -1);
    run(3, -1);
    chk("tmo_clear_state", 8'(state), 8'd1);
    chk("tmo_clear_err", 8'(error), 8'd0);

    // Held confirm in S1: exactly one transition.
    run(6, -1);
    confirm = 1'b1;
    run(50, -1);
    confirm = 1'b0;
    run(5, -1);
    chk("held_state", 8'(state), 8'd3);

    // Cancel from S3, then short re-press inside lockout from S0.
    press(1'b0, 1'b1, -1);
    run(8, -1);
    chk("cancel_s3_state", 8'(state), 8'd0);
    press(1'b1, 1'b0, -1);
    run(2, -1);
    press(1'b1, 1'b0, -1);
    run(8, -1);
    chk("lockout_state", 8'(state), 8'd1);

    // Cancel and confirm together in S3.
    press(1'b1, 1'b0, -1);
    run(9, -1);
    chk("prec_pre_state", 8'(state), 8'd3);
    wr_cnt = 0;
    press(1'b1, 1'b1, -1);
    run(8, -1);
    chk("prec_state", 8'(state), 8'd0);
    chk("prec_wr_cnt", 8'(wr_cnt), 8'd0);

    // Done in the timeout cycle.
    op_select = 2'b10;
    clear_obs();
    for (int p = 0; p < 3; p++) begin
      press(1'b1, 1'b0, 15);
      run(9, 15);
    end
    run(15, 15);
    chk("coll_s5_cycles", 8'(s5_cnt), 8'd16);
    chk("coll_rv", 8'(result_valid), 8'd1);
    chk("coll_err", 8'(error), 8'd0);
    chk("coll_alu_op", 8'(alu_op), 8'd2);

    // Asynchronous reset while alu_start is high.
    for (int p = 0; p < 2; p++) begin
      press(1'b1, 1'b0, -1);
      run(9, -1);
    end
    press(1'b1, 1'b0, -1);
    for (int i = 0; i < 10 && m_state != 5; i++) run(1, -1);
    chk("areset_pre_state", 8'(state), 8'd5);
    chk("areset_pre_start", 8'(alu_start), 8'd1);
    #3;
    reset_n = 1'b0;
    #1;
    chk_zero("areset");
    @(posedge clk);
    #1;
    chk_zero("areset_hold");
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    press(1'b1, 1'b0, -1);
    run(3, -1);
    chk("areset_after_state", 8'(state), 8'd1);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      confirm   = ($urandom_range(0, 2) == 0);
      cancel    = ($urandom_range(0, 24) == 0);
      op_select = 2'($urandom_range(0, 3));
      alu_done  = ($urandom_range(0, 5) == 0);
      tick();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
